// File: rtl/autobus_gen.sv
// Multi-channel framed packet generator: sop/eop/sof/eof, channel tags, rdy back-pressure.
// Optional macro AUTOBUS_GEN_PRBS_EN builds the mode-3 LFSR; without it mode 3 behaves as mode 0.
module autobus_gen #(
   parameter int DWID = 16,
   parameter int CHN  = 4,
   parameter int CWID = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [15:0]      pkt_len,
   input  logic [15:0]      frm_len,
   input  logic [15:0]      pkt_interval,
   input  logic [31:0]      seed,
   input  logic             rdy,
   output logic             sop,
   output logic             eop,
   output logic             sof,
   output logic             eof,
   output logic [CWID-1:0]  chn,
   output logic [DWID-1:0]  dat,
   output logic             dav,
   output logic [31:0]      pkt_cnt
);

   typedef enum logic [1:0] {IDLE, DATA, GAP} state_t;

   localparam int LW = DWID - CWID;
   localparam logic [32:0] DMAX = (33'd1 << DWID) - 33'd1;
   localparam logic [32:0] LMAX = (33'd1 << LW) - 33'd1;

   state_t state, state_nxt;

   logic [15:0]     b_q, l_q, gap_q;
   logic [CWID-1:0] c_q;
   logic [15:0]     len_q, frm_q, ivl_q;
   logic [1:0]      mode_q;
   logic [31:0]     seed_q;

   logic            at_fs, issue, last_beat, last_chn, last_line, cfg_ld;
   logic [15:0]     len_e, frm_e, ivl_e;
   logic [1:0]      mode_e;
   logic [31:0]     seed_e;
   logic [32:0]     b33;
   logic [DWID-1:0] dat_inc, dat_nxt;
   logic [LW-1:0]   lo;

   function automatic logic [15:0] nz(input logic [15:0] v);
      return (v == 16'd0) ? 16'd1 : v;
   endfunction

   // At a frame start the live inputs are used directly, so the sof beat already
   // sees new settings; they are captured when that beat issues and held for the frame.
   assign at_fs  = (b_q == 16'd0) && (c_q == '0) && (l_q == 16'd0);
   assign len_e  = at_fs ? nz(pkt_len) : len_q;
   assign frm_e  = at_fs ? nz(frm_len) : frm_q;
   assign mode_e = at_fs ? mode : mode_q;
   assign seed_e = at_fs ? seed : seed_q;
   assign ivl_e  = (b_q == 16'd0) ? pkt_interval : ivl_q;

   assign last_beat = (b_q == len_e - 16'd1);
   assign last_chn  = (c_q == CWID'(CHN - 1));
   assign last_line = (l_q == frm_e - 16'd1);

   assign b33     = {17'd0, b_q};
   assign dat_inc = (b33 > DMAX) ? DMAX[DWID-1:0] : b33[DWID-1:0];
   assign lo      = (b33 > LMAX) ? LMAX[LW-1:0] : b33[LW-1:0];

`ifdef AUTOBUS_GEN_PRBS_EN
   logic [31:0] lfsr_q, lfsr_e;

   function automatic logic [31:0] lstep(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   assign lfsr_e = at_fs ? ((seed_e == 32'd0) ? 32'd1 : seed_e) : lfsr_q;

   always_ff @(posedge clk) begin
      if (rst)        lfsr_q <= 32'd1;
      else if (issue) lfsr_q <= lstep(lfsr_e);
   end
`else
   logic unused_seed;
   assign unused_seed = ^seed_e;
`endif

   always_comb begin
      dat_nxt = dat_inc;
      unique case (mode_e)
         2'd0: dat_nxt = dat_inc;
         2'd1: dat_nxt = {c_q, lo};
         2'd2: dat_nxt = seed_e[DWID-1:0];
         default: begin
`ifdef AUTOBUS_GEN_PRBS_EN
            dat_nxt = lfsr_e[DWID-1:0];
`else
            dat_nxt = dat_inc;
`endif
         end
      endcase
   end

   // A new packet is never started while en is low; an open packet always completes.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      unique case (state)
         IDLE: if (en) state_nxt = DATA;
         DATA: begin
            if ((b_q == 16'd0) && !en) begin
               state_nxt = IDLE;
            end else begin
               issue = rdy;
               if (rdy && last_beat && (ivl_e != 16'd0)) state_nxt = GAP;
            end
         end
         GAP: if (gap_q == 16'd0) state_nxt = en ? DATA : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign cfg_ld = ((state == IDLE) && en) || (issue && at_fs);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         b_q    <= 16'd0;
         c_q    <= '0;
         l_q    <= 16'd0;
         gap_q  <= 16'd0;
         len_q  <= 16'd1;
         frm_q  <= 16'd1;
         ivl_q  <= 16'd0;
         mode_q <= 2'd0;
         seed_q <= 32'd0;
      end else begin
         state <= state_nxt;
         if (cfg_ld) begin
            len_q  <= len_e;
            frm_q  <= frm_e;
            mode_q <= mode_e;
            seed_q <= seed_e;
         end
         if (issue && (b_q == 16'd0)) ivl_q <= ivl_e;
         if (state_nxt == IDLE) begin
            b_q <= 16'd0;
            c_q <= '0;
            l_q <= 16'd0;
         end else if (issue) begin
            if (last_beat) begin
               b_q <= 16'd0;
               if (last_chn) begin
                  c_q <= '0;
                  l_q <= last_line ? 16'd0 : l_q + 16'd1;
               end else begin
                  c_q <= c_q + 1'b1;
               end
            end else begin
               b_q <= b_q + 16'd1;
            end
         end
         // GAP runs ivl cycles: load ivl-1 and leave when the count reaches zero.
         if (issue && last_beat)
            gap_q <= ivl_e - 16'd1;
         else if ((state == GAP) && (gap_q != 16'd0))
            gap_q <= gap_q - 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dav     <= 1'b0;
         sop     <= 1'b0;
         eop     <= 1'b0;
         sof     <= 1'b0;
         eof     <= 1'b0;
         chn     <= '0;
         dat     <= '0;
         pkt_cnt <= 32'd0;
      end else begin
         dav <= issue;
         sop <= issue && (b_q == 16'd0);
         eop <= issue && last_beat;
         sof <= issue && at_fs;
         eof <= issue && last_beat && last_chn && last_line;
         if (issue) begin
            chn <= c_q;
            dat <= dat_nxt;
         end
         if (issue && last_beat) pkt_cnt <= pkt_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_autobus_gen.sv
// Directed bench for autobus_gen: model-generated beats queued per run, popped as the DUT emits them.
module tb_autobus_gen;

   typedef struct packed {
      logic        sop, eop, sof, eof;
      logic [3:0]  chn;
      logic [15:0] dat;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst, en, en1, rdy;
   logic [1:0]  mode;
   logic [15:0] pkt_len, frm_len, pkt_interval;
   logic [31:0] seed;

   logic        sop, eop, sof, eof, dav;
   logic [3:0]  chn;
   logic [15:0] dat;
   logic [31:0] pkt_cnt;

   logic        sop1, eop1, sof1, eof1, dav1;
   logic [0:0]  chn1;
   logic [15:0] dat1;
   logic [31:0] pkt_cnt1;

   int checks = 0;
   int errors = 0;

   beat_t sb[$];
   beat_t e;
   bit    sb_on = 1'b1;
   bit    bp_chk = 1'b0;
   bit    seen_eop = 1'b0;
   int    exp_gap = -1;
   int    idle = 0;
   logic  rdy_edge = 1'b1;

   always #5 clk = ~clk;

   autobus_gen #(.DWID(16), .CHN(4), .CWID(4)) u_dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .pkt_len(pkt_len), .frm_len(frm_len),
      .pkt_interval(pkt_interval), .seed(seed), .rdy(rdy),
      .sop(sop), .eop(eop), .sof(sof), .eof(eof), .chn(chn), .dat(dat), .dav(dav),
      .pkt_cnt(pkt_cnt)
   );

   autobus_gen #(.DWID(16), .CHN(1), .CWID(1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en1), .mode(mode), .pkt_len(pkt_len), .frm_len(frm_len),
      .pkt_interval(pkt_interval), .seed(seed), .rdy(rdy),
      .sop(sop1), .eop(eop1), .sof(sof1), .eof(eof1), .chn(chn1), .dat(dat1), .dav(dav1),
      .pkt_cnt(pkt_cnt1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lstep(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   // Expected beats for the first npkts packets of a stream starting at sof.
   function automatic void push_pkts(input int md, input int len, input int frm, input int nchn,
                                     input logic [31:0] sd, input int npkts);
      int L, F, c, ln, lo;
      logic [31:0] lf;
      beat_t bt;
      L  = (len == 0) ? 1 : len;
      F  = (frm == 0) ? 1 : frm;
      lf = 32'd1;
      for (int p = 0; p < npkts; p++) begin
         c  = p % nchn;
         ln = (p / nchn) % F;
         if (c == 0 && ln == 0) lf = (sd == 32'd0) ? 32'd1 : sd;
         for (int b = 0; b < L; b++) begin
            bt.sop = (b == 0);
            bt.eop = (b == L - 1);
            bt.sof = (b == 0) && (c == 0) && (ln == 0);
            bt.eof = (b == L - 1) && (c == nchn - 1) && (ln == F - 1);
            bt.chn = c[3:0];
            lo = (b > 4095) ? 4095 : b;
            case (md)
               1: bt.dat = {c[3:0], lo[11:0]};
               2: bt.dat = sd[15:0];
`ifdef AUTOBUS_GEN_PRBS_EN
               3: begin bt.dat = lf[15:0]; lf = lstep(lf); end
`endif
               default: bt.dat = (b > 65535) ? 16'hFFFF : b[15:0];
            endcase
            sb.push_back(bt);
         end
      end
   endfunction

   always @(posedge clk) rdy_edge = rdy;

   always @(negedge clk) begin
      if (bp_chk && !rdy_edge) chk("bp_dav_low", dav, 1'b0);
      if (sb_on && dav) begin
         if (sb.size() == 0) begin
            chk("extra_beat", 1'b1, 1'b0);
         end else begin
            e = sb.pop_front();
            chk("markers", {sop, eop, sof, eof}, {e.sop, e.eop, e.sof, e.eof});
            chk("chn", chn, e.chn);
            chk("dat", dat, e.dat);
         end
         if (sop && exp_gap >= 0 && seen_eop) chk("gap_len", idle, exp_gap);
         if (eop) begin seen_eop = 1'b1; idle = 0; end
      end else if (!dav) begin
         idle++;
      end
   end

   task automatic wait_dav(input int bound);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!dav && n < bound);
      chk("dav_timeout", dav, 1'b1);
   endtask

   task automatic wait_eof(input int bound, input bit rnd);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         if (rnd) rdy = 1'($urandom_range(0, 1));
         n++;
      end while (!(dav && eof) && n < bound);
      chk("eof_timeout", dav && eof, 1'b1);
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while (sb.size() != 0 && n < bound) begin @(negedge clk); n++; end
      repeat (6) @(negedge clk);
      chk("queue_empty", sb.size(), 0);
   endtask

   task automatic cfg(input logic [1:0] m, input int len, input int frm, input int ivl,
                      input logic [31:0] sd);
      mode = m; pkt_len = len[15:0]; frm_len = frm[15:0]; pkt_interval = ivl[15:0]; seed = sd;
   endtask

   initial begin
      int nb;
      rst = 1'b1; en = 1'b0; en1 = 1'b0; rdy = 1'b1;
      cfg(2'd0, 8, 2, 3, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dav", dav, 1'b0);
      chk("rst_markers", {sop, eop, sof, eof}, 4'b0);
      chk("rst_chn_dat", {chn, dat}, 20'd0);
      chk("rst_pkt_cnt", pkt_cnt, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // mode 0 reference stream, rdy held high, 3-cycle gaps
      exp_gap = 3; seen_eop = 1'b0;
      push_pkts(0, 8, 2, 4, 32'd0, 8);
      en = 1'b1;
      wait_eof(300, 1'b0);
      en = 1'b0;
      drain(50);
      chk("pkt_cnt_8", pkt_cnt, 32'd8);
      exp_gap = -1;

      // same stream under random back-pressure
      bp_chk = 1'b1;
      push_pkts(0, 8, 2, 4, 32'd0, 8);
      en = 1'b1;
      wait_eof(2000, 1'b1);
      en = 1'b0;
      rdy = 1'b1;
      drain(100);
      bp_chk = 1'b0;

      // mode 1 long packet: low field saturates at 4095
      cfg(2'd1, 5000, 1, 0, 32'd0);
      push_pkts(1, 5000, 1, 4, 32'd0, 1);
      en = 1'b1;
      wait_dav(20);
      en = 1'b0;
      drain(6000);

      // mode 1 channel tagging over a full frame
      cfg(2'd1, 3, 1, 0, 32'd0);
      push_pkts(1, 3, 1, 4, 32'd0, 4);
      en = 1'b1;
      wait_eof(100, 1'b0);
      en = 1'b0;
      drain(50);

      // mode 2 constant
      cfg(2'd2, 3, 1, 1, 32'h1234_A5C3);
      push_pkts(2, 3, 1, 4, 32'h1234_A5C3, 4);
      en = 1'b1;
      wait_eof(100, 1'b0);
      en = 1'b0;
      drain(50);

      // mode 3 over two frames: sequence restarts at each sof
      cfg(2'd3, 4, 1, 0, 32'd1);
      push_pkts(3, 4, 1, 4, 32'd1, 8);
      en = 1'b1;
      wait_eof(100, 1'b0);
      wait_eof(100, 1'b0);
      en = 1'b0;
      drain(50);

      // zero lengths on the single-channel instance
      cfg(2'd0, 0, 0, 1, 32'd0);
      en1 = 1'b1;
      nb = 0;
      repeat (20) begin
         @(negedge clk);
         if (dav1) begin
            nb++;
            chk("bnd_markers", {sop1, eop1, sof1, eof1}, 4'hF);
            chk("bnd_dat", dat1, 16'd0);
         end
      end
      en1 = 1'b0;
      chk("bnd_beats", nb >= 5, 1'b1);

      // en dropped mid-packet: packet completes, restart begins with sof
      cfg(2'd0, 6, 2, 2, 32'd0);
      push_pkts(0, 6, 2, 4, 32'd0, 1);
      en = 1'b1;
      wait_dav(20);
      repeat (2) @(negedge clk);
      en = 1'b0;
      drain(50);
      push_pkts(0, 6, 2, 4, 32'd0, 1);
      en = 1'b1;
      wait_dav(20);
      en = 1'b0;
      drain(50);

      // reset mid-packet
      sb_on = 1'b0;
      en = 1'b1;
      wait_dav(20);
      chk("pkt_cnt_before_rst", pkt_cnt != 32'd0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_dav", dav, 1'b0);
      chk("rst_mid_pkt_cnt", pkt_cnt, 32'd0);
      chk("rst_mid_eop", eop, 1'b0);
      rst = 1'b0; en = 1'b0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/autobus_gen.md
# autobus_gen

Parametrised multi-channel successor to the single-channel `autobus` packet/frame generator. It emits framed packet streams with sop/eop/sof/eof markers and channel tagging, honours `rdy` back-pressure, and selects a data pattern at run time. It drives stimulus into downstream datapath blocks and serves as a self-checking source in benches.

## Interface

**Parameters**
- `DWID`, 16: data width, 8..32.
- `CHN`, 4: channel count, 1..16.
- `CWID`, 4: channel id width; must satisfy 2^CWID >= CHN and CWID < DWID.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `en`, in, 1: generation enable.
- `mode`, in, 2: 0 = inc, 1 = chan-inc, 2 = const, 3 = prbs.
- `pkt_len`, in, 16: beats per packet.
- `frm_len`, in, 16: lines per frame.
- `pkt_interval`, in, 16: idle cycles after each packet.
- `seed`, in, 32: constant value (mode 2) or LFSR seed (mode 3).
- `rdy`, in, 1: downstream ready.
- `sop`, `eop`, `sof`, `eof`, out, 1 each: packet and frame markers, valid only with `dav`.
- `chn`, out, CWID: channel of the current beat.
- `dat`, out, DWID: data.
- `dav`, out, 1: beat valid.
- `pkt_cnt`, out, 32: eop beats issued since reset; wraps.

## Operation

**Frame structure**
- A frame is `frm_len` lines. Each line is one packet per channel, in order 0..CHN-1.
- `sof` marks beat 0 of channel 0, line 0.
- `eof` marks the last beat of channel CHN-1 on the last line.

**Latching and zero values**
- `pkt_len`, `frm_len`, `mode` and `seed` are latched when leaving IDLE and at every sof.
- Mid-frame changes to these inputs take effect at the next frame. `pkt_interval` is latched at each sop.
- A value of 0 for `pkt_len` or `frm_len` is treated as 1. `pkt_interval` = 0 gives back-to-back packets.

**State machine**
- IDLE: leave to DATA when `en` = 1.
- DATA: a beat issues on every cycle where `rdy` = 1. The last beat of a packet goes to GAP, or directly to DATA if the interval is 0.
- GAP: count `pkt_interval` cycles, then return to DATA. If `en` is low at the end of GAP, go to IDLE instead.
- `en` falling mid-packet: the current packet completes, then the block returns to IDLE. Line and channel position reset, so the next start begins with sof. The interrupted frame gets no eof.

**Data patterns** (beat index b restarts at 0 on each sop)
- mode 0: dat = b, saturating at all-ones.
- mode 1: dat = {chn, b[DWID-CWID-1:0]}. The lower field saturates.
- mode 2: dat = seed[DWID-1:0] on every beat.
- mode 3: output of a 32-bit Fibonacci LFSR, x^32+x^22+x^2+x+1, taking the low DWID bits.
  - The LFSR is loaded with `seed` at each sof. A seed of 0 is replaced by 1.
  - It advances one step per issued beat and does not advance during stalls or GAP.

**Single-beat packet**: `sop` and `eop` are both asserted on the same beat. With `frm_len` = 1 and `CHN` = 1, `sof` and `eof` are also both asserted on that beat.

## Timing
- Outputs are registered. A beat whose `rdy` is sampled high at cycle t appears at cycle t+1 with `dav` = 1.
- When `rdy` = 0 in DATA: `dav` = 0 the next cycle, and counters and the LFSR hold their state.
- GAP lasts exactly `pkt_interval` cycles. `rdy` is ignored during GAP.
- First beat after the rising edge of `en`: `dav` is earliest at edge + 2 cycles.
- Reset: state IDLE, and all of `sop`, `eop`, `sof`, `eof`, `dav`, `chn`, `dat` and `pkt_cnt` are 0. Reset mid-packet aborts immediately with no eop.
- `pkt_cnt` increments on the cycle that the eop beat is presented. It wraps from 2^32-1 to 0.

## Configuration
- `AUTOBUS_GEN_PRBS_EN` defined: mode 3 is the LFSR as described above.
- `AUTOBUS_GEN_PRBS_EN` undefined: no LFSR logic is built, and mode 3 behaves exactly like mode 0.

## Test plan
- **Mode 0 stream:** CHN = 4, pkt_len = 8, frm_len = 2, interval = 3, rdy = 1.
  - Expect 8 packets. Each packet has dat 0..7.
  - chn sequence is 0,1,2,3,0,1,2,3.
  - sof on the first beat, eof on the 64th beat, 3 idle cycles between packets, pkt_cnt = 8.
- **Mode 1 tagging and saturation:** DWID = 16, CWID = 4, pkt_len = 5000.
  - Lower 12 bits of dat saturate at 4095 from beat 4095 onward.
  - dat[15:12] equals chn.
- **Back-pressure:** toggle rdy pseudo-randomly.
  - dav = 0 exactly one cycle after each sampled rdy = 0.
  - The issued sequence is identical to the rdy = 1 run, with no skipped or duplicated values.
- **Boundary values:** pkt_len = 0, frm_len = 0, CHN = 1.
  - Every beat has sop, eop, sof and eof all equal to 1, with dat = 0.
- **Mode 3 PRBS:** seed = 0x1, with AUTOBUS_GEN_PRBS_EN defined.
  - dat matches the bench LFSR model, and the sequence restarts at each sof.
  - With the macro undefined, mode 3 output matches mode 0.
- **Interruption:**
  - Drop en mid-packet: the packet completes with eop, then the block idles; on re-enable the first beat carries sof.
  - Assert rst mid-packet: dav = 0 on the next cycle and pkt_cnt = 0.
